// File: rtl/button_event_pkg.sv
// -----------------------------------------------------------------------------
// button_event_pkg
// Shared definitions for the debounced button event block:
//   - CLOCK_FREQUENCY of the system clock
//   - default debounce / repeat-delay / repeat-period cycle counts
//   - button_state_t, the per-channel debounce FSM state
//   - max_int(), used to size counters that compare against two limits
// -----------------------------------------------------------------------------
package button_event_pkg;

    localparam int CLOCK_FREQUENCY = 50_000_000;

    // 20 ms, 500 ms and 100 ms at CLOCK_FREQUENCY.
    localparam int DEFAULT_DEBOUNCE_CYCLES      = CLOCK_FREQUENCY / 50;
    localparam int DEFAULT_REPEAT_DELAY_CYCLES  = CLOCK_FREQUENCY / 2;
    localparam int DEFAULT_REPEAT_PERIOD_CYCLES = CLOCK_FREQUENCY / 10;

    typedef enum logic [1:0] {
        RELEASED        = 2'd0,
        PRESS_PENDING   = 2'd1,
        PRESSED         = 2'd2,
        RELEASE_PENDING = 2'd3
    } button_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One debounced button: two-flop synchronizer, debounce counter, optional
// hold-to-repeat counter and the RELEASED / PRESS_PENDING / PRESSED /
// RELEASE_PENDING FSM. All outputs are registered.
//
// Build option: BUTTON_EVENT_REPEAT_EN enables hold-to-repeat pulses.
//
// Ports:
//   clock       system clock
//   reset_s2_n  asynchronous active-low reset
//   button_n_i  raw asynchronous button, 0 = pressed
//   pressed_o   one-cycle pulse per accepted press (and per repeat)
//   released_o  one-cycle pulse per accepted release
//   level_o     debounced state, 1 = held
// -----------------------------------------------------------------------------
module button_channel
    import button_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES
`ifdef BUTTON_EVENT_REPEAT_EN
   ,parameter int REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES
   ,parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
`endif
) (
    input  logic clock,
    input  logic reset_s2_n,
    input  logic button_n_i,
    output logic pressed_o,
    output logic released_o,
    output logic level_o
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             btn_held;
    logic [DEB_W-1:0] deb_cnt_q;
    button_state_t    state_q;
    logic             pressed_q;
    logic             released_q;
    logic             level_q;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam int REP_W = $clog2(max_int(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES), 2));
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q;
    // Set once the first (delay) repeat has fired; later repeats use the period.
    logic             rep_after_first_q;
    logic [REP_W-1:0] rep_limit;

    assign rep_limit = rep_after_first_q ? REP_PERIOD_LAST : REP_DELAY_LAST;
`endif

    assign btn_held = ~sync2_q;

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            // Synchronizer resets to "released" so a button held through reset
            // is seen as a fresh press afterwards.
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= RELEASED;
            deb_cnt_q  <= '0;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;
            level_q    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
            rep_cnt_q         <= '0;
            rep_after_first_q <= 1'b0;
`endif
        end else begin
            sync1_q    <= button_n_i;
            sync2_q    <= sync1_q;
            pressed_q  <= 1'b0;
            released_q <= 1'b0;

            case (state_q)
                RELEASED: begin
                    if (btn_held) begin
                        state_q   <= PRESS_PENDING;
                        deb_cnt_q <= '0;
                    end
                end

                PRESS_PENDING: begin
                    if (!btn_held) begin
                        state_q <= RELEASED;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q   <= PRESSED;
                        pressed_q <= 1'b1;
                        level_q   <= 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                        rep_cnt_q         <= '0;
                        rep_after_first_q <= 1'b0;
`endif
                    end else begin
                        // Stops at DEB_LAST, so the counter never wraps.
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!btn_held) begin
                        state_q   <= RELEASE_PENDING;
                        deb_cnt_q <= '0;
                    end
`ifdef BUTTON_EVENT_REPEAT_EN
                    else if (rep_cnt_q == rep_limit) begin
                        pressed_q         <= 1'b1;
                        rep_cnt_q         <= '0;
                        rep_after_first_q <= 1'b1;
                    end else if (rep_cnt_q != '1) begin
                        rep_cnt_q <= rep_cnt_q + 1'b1;
                    end
`endif
                end

                RELEASE_PENDING: begin
                    // Repeat counter is left untouched here and resumes on bounce-back.
                    if (btn_held) begin
                        state_q <= PRESSED;
                    end else if (deb_cnt_q == DEB_LAST) begin
                        state_q    <= RELEASED;
                        released_q <= 1'b1;
                        level_q    <= 1'b0;
                    end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                    end
                end

                default: state_q <= RELEASED;
            endcase
        end
    end

    assign pressed_o  = pressed_q;
    assign released_o = released_q;
    assign level_o    = level_q;

endmodule

// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
// Debounces BUTTON_COUNT raw active-low push buttons and emits one-cycle press
// and release pulses per button. Channels are independent; simultaneous events
// produce simultaneous pulses.
//
// Build option: BUTTON_EVENT_REPEAT_EN enables hold-to-repeat press pulses
// (REPEAT_DELAY_CYCLES after the press, then every REPEAT_PERIOD_CYCLES).
//
// Ports:
//   clock       50 MHz system clock
//   reset_s2_n  asynchronous active-low reset
//   button_n    raw asynchronous buttons, 0 = pressed
//   pressed     one-cycle pulse per accepted press (and per repeat)
//   released    one-cycle pulse per accepted release
//   level       debounced state, 1 = held
// -----------------------------------------------------------------------------
module button_event
    import button_event_pkg::*;
#(
    parameter int BUTTON_COUNT         = 2,
    parameter int DEBOUNCE_CYCLES      = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES  = DEFAULT_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_PERIOD_CYCLES = DEFAULT_REPEAT_PERIOD_CYCLES
) (
    input  logic                    clock,
    input  logic                    reset_s2_n,
    input  logic [BUTTON_COUNT-1:0] button_n,
    output logic [BUTTON_COUNT-1:0] pressed,
    output logic [BUTTON_COUNT-1:0] released,
    output logic [BUTTON_COUNT-1:0] level
);

    genvar gi;
    generate
        for (gi = 0; gi < BUTTON_COUNT; gi++) begin : g_channel
            button_channel #(
                .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES)
`ifdef BUTTON_EVENT_REPEAT_EN
               ,.REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES)
               ,.REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
`endif
            ) u_channel (
                .clock      (clock),
                .reset_s2_n (reset_s2_n),
                .button_n_i (button_n[gi]),
                .pressed_o  (pressed[gi]),
                .released_o (released[gi]),
                .level_o    (level[gi])
            );
        end

`ifndef BUTTON_EVENT_REPEAT_EN
        // Repeat timing is not built in this configuration; the parameters stay
        // on the interface so instantiations are identical in both builds.
        if (REPEAT_DELAY_CYCLES < 1 || REPEAT_PERIOD_CYCLES < 1) begin : g_repeat_cfg_unused
        end
`endif
    endgenerate

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
// Scoreboard bench for button_event with DEBOUNCE_CYCLES=8,
// REPEAT_DELAY_CYCLES=32, REPEAT_PERIOD_CYCLES=16. Expected pulse events
// (cycle, pressed, released) are queued when stimulus is driven; a monitor
// pops and compares each event the DUT produces. Scenario tasks add inline
// level / completeness checks.
// -----------------------------------------------------------------------------
module tb_button_event;

    localparam int D      = 8;
    localparam int RDELAY = 32;
    localparam int RPER   = 16;

    typedef struct packed {
        int         cyc;
        logic [1:0] p;
        logic [1:0] r;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] button_n;
    logic [1:0] pressed;
    logic [1:0] released;
    logic [1:0] level;

    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;
    ev_t exp_q[$];

    button_event #(
        .BUTTON_COUNT         (2),
        .DEBOUNCE_CYCLES      (D),
        .REPEAT_DELAY_CYCLES  (RDELAY),
        .REPEAT_PERIOD_CYCLES (RPER)
    ) dut (
        .clock      (clk),
        .reset_s2_n (rst_n),
        .button_n   (button_n),
        .pressed    (pressed),
        .released   (released),
        .level      (level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every pulse the DUT emits must match the head of exp_q.
    always @(negedge clk) begin
        if ((pressed | released) != 2'b00) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event cyc=%0d pressed=%b released=%b (none expected)",
                         cyc, pressed, released);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc !== cyc || e.p !== pressed || e.r !== released) begin
                    bad++;
                    $display("FAIL event got cyc=%0d p=%b r=%b expected cyc=%0d p=%b r=%b",
                             cyc, pressed, released, e.cyc, e.p, e.r);
                end
            end
        end
    end

    // Event for a level change driven at the current negedge.
    function automatic ev_t expect_at(input int c, input logic [1:0] p, input logic [1:0] r);
        ev_t e;
        e.cyc = c + D + 3;
        e.p   = p;
        e.r   = r;
        return e;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        button_n = 2'b11;
        #1;
        total++;
        if ({pressed, released, level} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs got %b expected 000000", {pressed, released, level});
        end
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(4);
        total++;
        if ({pressed, released, level} !== 6'b0) begin
            bad++;
            $display("FAIL idle_after_reset got %b expected 000000", {pressed, released, level});
        end
    endtask

    task automatic test_clean_press;
        button_n[0] = 1'b0;
        exp_q.push_back(expect_at(cyc, 2'b01, 2'b00));
        wait_cycles(D + 2);
        total++;
        if (level !== 2'b00) begin
            bad++;
            $display("FAIL press_level_early got %b expected 00", level);
        end
        wait_cycles(1);
        total++;
        if (level !== 2'b01) begin
            bad++;
            $display("FAIL press_level got %b expected 01", level);
        end
        wait_cycles(1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL press_missing got %0d pending expected 0", exp_q.size());
        end
    endtask

    task automatic test_release;
        // Short glitch high during the hold must not produce any event.
        button_n[0] = 1'b1;
        wait_cycles(3);
        button_n[0] = 1'b0;
        wait_cycles(10);
        total++;
        if (level !== 2'b01) begin
            bad++;
            $display("FAIL glitch_level got %b expected 01", level);
        end
        button_n[0] = 1'b1;
        exp_q.push_back(expect_at(cyc, 2'b00, 2'b01));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b00 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL release got level=%b pending=%0d expected level=00 pending=0",
                     level, exp_q.size());
        end
    endtask

    task automatic test_bounce;
        button_n[0] = 1'b0;
        wait_cycles(5);
        button_n[0] = 1'b1;
        wait_cycles(3);
        button_n[0] = 1'b0;
        exp_q.push_back(expect_at(cyc, 2'b01, 2'b00));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b01 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_press got level=%b pending=%0d expected level=01 pending=0",
                     level, exp_q.size());
        end
        button_n[0] = 1'b1;
        exp_q.push_back(expect_at(cyc, 2'b00, 2'b01));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b00 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bounce_release got level=%b pending=%0d expected level=00 pending=0",
                     level, exp_q.size());
        end
    endtask

    task automatic test_simultaneous;
        button_n = 2'b00;
        exp_q.push_back(expect_at(cyc, 2'b11, 2'b00));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b11 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL simul_press got level=%b pending=%0d expected level=11 pending=0",
                     level, exp_q.size());
        end
        button_n = 2'b11;
        exp_q.push_back(expect_at(cyc, 2'b00, 2'b11));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b00 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL simul_release got level=%b pending=%0d expected level=00 pending=0",
                     level, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_press;
        button_n[0] = 1'b0;
        exp_q.push_back(expect_at(cyc, 2'b01, 2'b00));
        wait_cycles(D + 6);
        rst_n = 1'b0;
        #1;
        total++;
        if ({pressed, released, level} !== 6'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_press got outs=%b pending=%0d expected outs=000000 pending=0",
                     {pressed, released, level}, exp_q.size());
        end
        wait_cycles(3);
        rst_n = 1'b1;
        exp_q.push_back(expect_at(cyc, 2'b01, 2'b00));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b01 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL repress_after_reset got level=%b pending=%0d expected level=01 pending=0",
                     level, exp_q.size());
        end
        button_n[0] = 1'b1;
        exp_q.push_back(expect_at(cyc, 2'b00, 2'b01));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b00 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL release_after_reset got level=%b pending=%0d expected level=00 pending=0",
                     level, exp_q.size());
        end
    endtask

    task automatic test_repeat;
        int accept;
        button_n[1] = 1'b0;
        accept = cyc + D + 3;
        exp_q.push_back(expect_at(cyc, 2'b10, 2'b00));
`ifdef BUTTON_EVENT_REPEAT_EN
        for (int k = 0; k < 4; k++) begin
            ev_t e;
            e.cyc = accept + RDELAY + k * RPER;
            e.p   = 2'b10;
            e.r   = 2'b00;
            exp_q.push_back(e);
        end
`endif
        wait_cycles(D + 3 + 82);
        total++;
        if (level !== 2'b10 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL repeat_hold got level=%b pending=%0d expected level=10 pending=0",
                     level, exp_q.size());
        end
        button_n[1] = 1'b1;
        exp_q.push_back(expect_at(cyc, 2'b00, 2'b10));
        wait_cycles(D + 5);
        total++;
        if (level !== 2'b00 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL repeat_release got level=%b pending=%0d expected level=00 pending=0",
                     level, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_clean_press();
        test_release();
        wait_cycles(4);
        test_bounce();
        wait_cycles(4);
        test_simultaneous();
        wait_cycles(4);
        test_reset_mid_press();
        wait_cycles(4);
        test_repeat();
        wait_cycles(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
